simd_issue_sequencer: RTL and testbench

Single-issue sequencer between the instruction decoder and the SIMD register file and execution units. It accepts one decoded instruction at a time with a valid/ready handshake and issues register-file reads. It then starts exactly one execution unit (add, sub, mul, bitrev), waits that unit's latency and issues the writeback. It also back-pressures the program counter through `instr_ready` and counts retired instructions.

---
 rtl/simd_issue_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_simd_issue_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_issue_sequencer.sv
// simd_issue_sequencer
// Single-issue sequencer between the decoder and the SIMD register file and
// execution units. One instruction is in flight at a time: register reads,
// one execution unit start, a latency dwell, then writeback.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a decoded instruction; instr_ready may be high
// READ  | register-file read strobes are out (one cycle)
// EXEC  | unit started on first cycle; dwell of the unit's latency
// WB    | writeback strobe is out, retire count bumps on completion
//
// All outputs except instr_ready are registered. A strobe register is
// loaded at the enabled edge that enters the state owning that strobe,
// so each strobe fires once per instruction no matter how long enable
// stays low. A low enable clears the strobes and freezes the state,
// the latency counter and the captured fields.

module simd_issue_sequencer #(
   parameter int unsigned ADD_LAT    = 1,
   parameter int unsigned SUB_LAT    = 1,
   parameter int unsigned BITREV_LAT = 1,
   parameter int unsigned MUL_LAT    = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic        add_en_i,
   input  logic        sub_en_i,
   input  logic        mul_en_i,
   input  logic        bitrev_en_i,
   input  logic        rs1_rd_en_i,
   input  logic        rs2_rd_en_i,
   input  logic        rd_wr_en_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [4:0]  rd_i,
   output logic        rf_rs1_rd_en_o,
   output logic        rf_rs2_rd_en_o,
   output logic [4:0]  rf_rs1_addr_o,
   output logic [4:0]  rf_rs2_addr_o,
   output logic [3:0]  exec_start_o,
   output logic        rf_wr_en_o,
   output logic [4:0]  rf_wr_addr_o,
   output logic        busy_o,
   output logic        err_illegal_o,
   output logic [15:0] retired_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  op_q;
   logic        rd_wr_en_q;
   logic [4:0]  rd_q;

   logic        rf_rs1_rd_en_q;
   logic        rf_rs2_rd_en_q;
   logic [4:0]  rf_rs1_addr_q;
   logic [4:0]  rf_rs2_addr_q;
   logic [3:0]  exec_start_q;
   logic        rf_wr_en_q;
   logic [4:0]  rf_wr_addr_q;
   logic        busy_q;
   logic        err_illegal_q;
   logic [15:0] retired_cnt_q;

   // op select packed in exec_start bit order {mul, bitrev, sub, add}
   logic [3:0]  op_vec_d;
   logic [2:0]  op_cnt_d;
   logic        op_legal_d;
   logic        op_nop_d;
   logic [3:0]  lat_d;

   // Classify the instruction on the decoder bus: legal, NOP or illegal.
   always_comb begin
      op_vec_d   = {mul_en_i, bitrev_en_i, sub_en_i, add_en_i};
      op_cnt_d   = {2'b00, op_vec_d[0]} + {2'b00, op_vec_d[1]}
                 + {2'b00, op_vec_d[2]} + {2'b00, op_vec_d[3]};
      op_legal_d = (op_cnt_d == 3'd1);
      op_nop_d   = (op_cnt_d == 3'd0) && !rd_wr_en_i;
   end

   // Latency of the captured op, loaded into the dwell counter on READ exit.
   always_comb begin
      lat_d = 4'd1;
      case (op_q)
         4'b0001: lat_d = 4'(ADD_LAT);
         4'b0010: lat_d = 4'(SUB_LAT);
         4'b0100: lat_d = 4'(BITREV_LAT);
         4'b1000: lat_d = 4'(MUL_LAT);
         default: lat_d = 4'd1;
      endcase
   end

   // Ready is the only combinational output: it must track enable and reset
   // in the same cycle so the PC never advances on a frozen or reset sequencer.
   assign instr_ready_o = (state_q == S_IDLE) && enable_i && !rst_i;

   // Sequencer FSM with registered strobes, addresses, busy and retire count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         op_q           <= 4'd0;
         rd_wr_en_q     <= 1'b0;
         rd_q           <= 5'd0;
         rf_rs1_rd_en_q <= 1'b0;
         rf_rs2_rd_en_q <= 1'b0;
         rf_rs1_addr_q  <= 5'd0;
         rf_rs2_addr_q  <= 5'd0;
         exec_start_q   <= 4'd0;
         rf_wr_en_q     <= 1'b0;
         rf_wr_addr_q   <= 5'd0;
         busy_q         <= 1'b0;
         err_illegal_q  <= 1'b0;
         retired_cnt_q  <= 16'd0;
      end else begin
         rf_rs1_rd_en_q <= 1'b0;
         rf_rs2_rd_en_q <= 1'b0;
         exec_start_q   <= 4'd0;
         rf_wr_en_q     <= 1'b0;
         err_illegal_q  <= 1'b0;
         if (enable_i) begin
            case (state_q)
               S_IDLE: begin
                  if (instr_valid_i) begin
                     if (op_legal_d) begin
                        op_q           <= op_vec_d;
                        rd_wr_en_q     <= rd_wr_en_i;
                        rd_q           <= rd_i;
                        rf_rs1_rd_en_q <= rs1_rd_en_i;
                        rf_rs2_rd_en_q <= rs2_rd_en_i;
                        if (rs1_rd_en_i) begin
                           rf_rs1_addr_q <= rs1_i;
                        end
                        if (rs2_rd_en_i) begin
                           rf_rs2_addr_q <= rs2_i;
                        end
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                     end else if (!op_nop_d) begin
                        err_illegal_q <= 1'b1;
                     end
                  end
               end
               S_READ: begin
                  cnt_q        <= lat_d;
                  exec_start_q <= op_q;
                  state_q      <= S_EXEC;
               end
               S_EXEC: begin
                  if (cnt_q <= 4'd1) begin
                     rf_wr_en_q <= rd_wr_en_q;
                     if (rd_wr_en_q) begin
                        rf_wr_addr_q <= rd_q;
                     end
                     state_q <= S_WB;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
               S_WB: begin
                  retired_cnt_q <= retired_cnt_q + 16'd1;
                  state_q       <= S_IDLE;
                  busy_q        <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rf_rs1_rd_en_o = rf_rs1_rd_en_q;
   assign rf_rs2_rd_en_o = rf_rs2_rd_en_q;
   assign rf_rs1_addr_o  = rf_rs1_addr_q;
   assign rf_rs2_addr_o  = rf_rs2_addr_q;
   assign exec_start_o   = exec_start_q;
   assign rf_wr_en_o     = rf_wr_en_q;
   assign rf_wr_addr_o   = rf_wr_addr_q;
   assign busy_o         = busy_q;
   assign err_illegal_o  = err_illegal_q;
   assign retired_cnt_o  = retired_cnt_q;

endmodule

// File: tb/tb_simd_issue_sequencer.sv
// Directed testbench for simd_issue_sequencer (default latencies, MUL_LAT=3).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Cycle T+k below is the k-th cycle after the edge T that accepts an instruction.

module tb_simd_issue_sequencer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        instr_valid;
   logic        instr_ready;
   logic        add_en, sub_en, mul_en, bitrev_en;
   logic        rs1_rd_en, rs2_rd_en, rd_wr_en;
   logic [4:0]  rs1, rs2, rd;
   logic        rf_rs1_rd_en, rf_rs2_rd_en;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr;
   logic [3:0]  exec_start;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic        busy;
   logic        err_illegal;
   logic [15:0] retired_cnt;

   int n_chk;
   int n_fail;
   int ex_cnt;
   int wr_cnt;

   simd_issue_sequencer #(
      .ADD_LAT    (1),
      .SUB_LAT    (1),
      .BITREV_LAT (1),
      .MUL_LAT    (3)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .instr_valid_i  (instr_valid),
      .instr_ready_o  (instr_ready),
      .add_en_i       (add_en),
      .sub_en_i       (sub_en),
      .mul_en_i       (mul_en),
      .bitrev_en_i    (bitrev_en),
      .rs1_rd_en_i    (rs1_rd_en),
      .rs2_rd_en_i    (rs2_rd_en),
      .rd_wr_en_i     (rd_wr_en),
      .rs1_i          (rs1),
      .rs2_i          (rs2),
      .rd_i           (rd),
      .rf_rs1_rd_en_o (rf_rs1_rd_en),
      .rf_rs2_rd_en_o (rf_rs2_rd_en),
      .rf_rs1_addr_o  (rf_rs1_addr),
      .rf_rs2_addr_o  (rf_rs2_addr),
      .exec_start_o   (exec_start),
      .rf_wr_en_o     (rf_wr_en),
      .rf_wr_addr_o   (rf_wr_addr),
      .busy_o         (busy),
      .err_illegal_o  (err_illegal),
      .retired_cnt_o  (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic a, input logic s, input logic m,
                            input logic b, input logic e1, input logic e2, input logic ew,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rw);
      instr_valid = v;
      add_en      = a;
      sub_en      = s;
      mul_en      = m;
      bitrev_en   = b;
      rs1_rd_en   = e1;
      rs2_rd_en   = e2;
      rd_wr_en    = ew;
      rs1         = r1;
      rs2         = r2;
      rd          = rw;
   endtask

   task automatic clear_instr();
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      enable = 1'b1;
      clear_instr();

      // ---------------- reset
      step();
      check("rdy_in_rst", 32'(instr_ready), 32'd0);
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_retired", 32'(retired_cnt), 32'd0);
      check("rst_exec", 32'(exec_start), 32'd0);
      check("rst_wr_en", 32'(rf_wr_en), 32'd0);
      check("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
      check("rst_rs1_addr", 32'(rf_rs1_addr), 32'd0);
      check("rst_err", 32'(err_illegal), 32'd0);
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 32'(instr_ready), 32'd1);

      // ---------------- add rs1=3 rs2=4 rd=5, valid held until ready returns
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5);
      step();  // T+1 READ
      check("add_rd1_en", 32'(rf_rs1_rd_en), 32'd1);
      check("add_rd1_addr", 32'(rf_rs1_addr), 32'd3);
      check("add_rd2_en", 32'(rf_rs2_rd_en), 32'd1);
      check("add_rd2_addr", 32'(rf_rs2_addr), 32'd4);
      check("add_rdy_t1", 32'(instr_ready), 32'd0);
      check("add_busy_t1", 32'(busy), 32'd1);
      check("add_exec_t1", 32'(exec_start), 32'd0);
      step();  // T+2
      check("add_exec_t2", 32'(exec_start), 32'h1);
      check("add_rd1_t2", 32'(rf_rs1_rd_en), 32'd0);
      step();  // T+3
      check("add_exec_t3", 32'(exec_start), 32'd0);
      check("add_wr_en_t3", 32'(rf_wr_en), 32'd1);
      check("add_wr_addr_t3", 32'(rf_wr_addr), 32'd5);
      step();  // T+4
      check("add_rdy_t4", 32'(instr_ready), 32'd1);
      check("add_retired", 32'(retired_cnt), 32'd1);
      check("add_wr_en_t4", 32'(rf_wr_en), 32'd0);
      check("add_busy_t4", 32'(busy), 32'd0);
      clear_instr();

      // ---------------- mul rd=31, MUL_LAT=3
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd8, 5'd31);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 1) clear_instr();
         check($sformatf("mul_busy_t%0d", k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
         check($sformatf("mul_wr_en_t%0d", k), 32'(rf_wr_en), (k == 5) ? 32'd1 : 32'd0);
         check($sformatf("mul_exec_t%0d", k), 32'(exec_start), (k == 2) ? 32'h8 : 32'd0);
         check($sformatf("mul_rdy_t%0d", k), 32'(instr_ready), (k == 6) ? 32'd1 : 32'd0);
         if (k == 5) check("mul_wr_addr", 32'(rf_wr_addr), 32'd31);
      end
      check("mul_retired", 32'(retired_cnt), 32'd2);

      // ---------------- sub without rs2 read or writeback: addresses hold
      set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 5'd20, 5'd12);
      step();
      clear_instr();
      check("sub_rd1_en", 32'(rf_rs1_rd_en), 32'd1);
      check("sub_rd1_addr", 32'(rf_rs1_addr), 32'd9);
      check("sub_rd2_en", 32'(rf_rs2_rd_en), 32'd0);
      check("sub_rd2_addr_hold", 32'(rf_rs2_addr), 32'd8);
      step();
      check("sub_exec", 32'(exec_start), 32'h2);
      step();
      check("sub_wr_en", 32'(rf_wr_en), 32'd0);
      check("sub_wr_addr_hold", 32'(rf_wr_addr), 32'd31);
      step();
      check("sub_retired", 32'(retired_cnt), 32'd3);
      check("sub_rdy", 32'(instr_ready), 32'd1);

      // ---------------- illegal (two ops), NOP, zero-op with rd_wr_en
      set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      #1;
      check("ill_rdy0", 32'(instr_ready), 32'd1);
      step();
      check("ill_err0", 32'(err_illegal), 32'd1);
      check("ill_rd1_0", 32'(rf_rs1_rd_en), 32'd0);
      check("ill_busy0", 32'(busy), 32'd0);
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      check("ill_rdy1", 32'(instr_ready), 32'd1);
      step();
      check("ill_err1", 32'(err_illegal), 32'd0);
      check("ill_exec1", 32'(exec_start), 32'd0);
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6);
      #1;
      check("ill_rdy2", 32'(instr_ready), 32'd1);
      step();
      clear_instr();
      check("ill_err2", 32'(err_illegal), 32'd1);
      check("ill_wr_en2", 32'(rf_wr_en), 32'd0);
      step();
      check("ill_err_end", 32'(err_illegal), 32'd0);
      check("ill_retired", 32'(retired_cnt), 32'd3);
      check("ill_busy_end", 32'(busy), 32'd0);

      // ---------------- enable low for 4 cycles mid-EXEC of a mul
      ex_cnt = 0;
      wr_cnt = 0;
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd17);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) clear_instr();
         if (exec_start != 4'd0) ex_cnt++;
         if (rf_wr_en) wr_cnt++;
         if (k >= 4 && k <= 7) begin
            check($sformatf("frz_exec_t%0d", k), 32'(exec_start), 32'd0);
            check($sformatf("frz_wr_t%0d", k), 32'(rf_wr_en), 32'd0);
            check($sformatf("frz_rdy_t%0d", k), 32'(instr_ready), 32'd0);
            check($sformatf("frz_busy_t%0d", k), 32'(busy), 32'd1);
         end
         check($sformatf("frz_wr_pos_t%0d", k), 32'(rf_wr_en), (k == 9) ? 32'd1 : 32'd0);
         if (k == 9) check("frz_wr_addr", 32'(rf_wr_addr), 32'd17);
         if (k == 3) enable = 1'b0;
         if (k == 7) enable = 1'b1;
      end
      check("frz_exec_pulses", 32'(ex_cnt), 32'd1);
      check("frz_wr_pulses", 32'(wr_cnt), 32'd1);
      check("frz_retired", 32'(retired_cnt), 32'd4);
      check("frz_rdy_end", 32'(instr_ready), 32'd1);

      // ---------------- reset in the second EXEC cycle of a mul
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3, 5'd22);
      step();
      clear_instr();
      step();
      check("rmid_exec_t2", 32'(exec_start), 32'h8);
      step();
      rst = 1'b1;
      step();
      check("rmid_busy", 32'(busy), 32'd0);
      check("rmid_wr_en", 32'(rf_wr_en), 32'd0);
      check("rmid_retired", 32'(retired_cnt), 32'd0);
      check("rmid_rdy_in_rst", 32'(instr_ready), 32'd0);
      check("rmid_wr_addr", 32'(rf_wr_addr), 32'd0);
      rst = 1'b0;
      #1;
      check("rmid_rdy", 32'(instr_ready), 32'd1);
      wr_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (rf_wr_en) wr_cnt++;
      end
      check("rmid_no_wb", 32'(wr_cnt), 32'd0);
      check("rmid_busy_end", 32'(busy), 32'd0);

      // ---------------- retire counter wrap: preset near the top, then bitrevs
      force dut.retired_cnt_q = 16'hFFFE;
      #1;
      release dut.retired_cnt_q;
      #1;
      check("wrap_preset", 32'(retired_cnt), 32'hFFFE);
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 5'd5, 5'd6);
      wr_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (rf_wr_en) wr_cnt++;
         if (k == 2 || k == 6) check($sformatf("wrap_exec_t%0d", k), 32'(exec_start), 32'h4);
         if (k == 4) check("wrap_ffff", 32'(retired_cnt), 32'hFFFF);
         if (k == 8) check("wrap_zero", 32'(retired_cnt), 32'h0000);
      end
      clear_instr();
      check("wrap_no_wr", 32'(wr_cnt), 32'd0);
      step();
      check("wrap_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
